// File: rtl/wb_fml_bridge.sv
// wb_fml_bridge
//   Converts single-beat Wishbone accesses into 4-word FML line bursts for the
//   DDR controller. A one-line read buffer serves repeated reads within the
//   same 16-byte line without DDR traffic. Writes go straight through to DDR:
//   all four words of the line are pushed, and only the addressed word carries
//   byte enables.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   wb_cyc_i/wb_stb_i       Wishbone request (cyc & stb)
//   wb_we_i                 1 = write
//   wb_adr_i                byte address, bits [adr_width-1:2] used
//   wb_dat_i, wb_sel_i      write data and byte selects
//   wb_dat_o, wb_ack_o      read data and one-cycle acknowledge
//   fml_adr                 line-aligned burst address
//   fml_rd, fml_wr          burst requests, held until fml_done
//   fml_done                command accept from the controller
//   fml_wdat/wbe/wnext      write FIFO push port
//   fml_rempty/rnext/rdat   read FIFO pop port (first-word fall-through)
module wb_fml_bridge #(
  parameter int adr_width = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic [31:0]          wb_dat_o,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] fml_adr,
  output logic                 fml_rd,
  output logic                 fml_wr,
  input  logic                 fml_done,
  output logic [31:0]          fml_wdat,
  output logic [3:0]           fml_wbe,
  output logic                 fml_wnext,
  input  logic                 fml_rempty,
  output logic                 fml_rnext,
  input  logic [31:0]          fml_rdat
);

  typedef enum logic [2:0] {IDLE, WPUSH, WCMD, RCMD, RFILL, ACK} state_t;

  state_t state;
  state_t state_next;

  logic                 req;
  logic [adr_width-5:0] adr_tag;
  logic                 hit;
  logic                 pop;

  logic [adr_width-1:2] req_adr;
  logic                 req_we;
  logic [31:0]          req_dat;
  logic [3:0]           req_sel;
  logic [1:0]           req_idx;
  logic [adr_width-5:0] req_tag;

  logic [adr_width-5:0] buf_tag;
  logic                 buf_valid;
  logic [31:0]          buf_mem [4];
  logic [1:0]           cnt;

  // Address bits above the FML space and the byte offset are not used.
  logic                 unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:adr_width], wb_adr_i[1:0]};

  assign req     = wb_cyc_i & wb_stb_i;
  assign adr_tag = wb_adr_i[adr_width-1:4];
  assign hit     = buf_valid && (buf_tag == adr_tag);
  assign req_idx = req_adr[3:2];
  assign req_tag = req_adr[adr_width-1:4];
  assign pop     = (state == RFILL) && !fml_rempty;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. A request is only looked at in IDLE; once accepted the
  // burst always runs to completion even if the master drops cyc.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (wb_we_i)  state_next = WPUSH;
          else if (hit) state_next = ACK;
          else          state_next = RCMD;
        end
      end
      WPUSH: if (cnt == 2'd3)          state_next = WCMD;
      WCMD:  if (fml_done)             state_next = ACK;
      RCMD:  if (fml_done)             state_next = RFILL;
      RFILL: if (pop && cnt == 2'd3)   state_next = ACK;
      ACK:                             state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Request capture, word counter and line buffer. The request is latched on
  // acceptance so the burst stays self-consistent if the master lets go of
  // the bus mid-transaction. A read miss invalidates the buffer and claims
  // its tag before the burst; a write hitting the buffered line merges its
  // selected bytes once the controller has accepted the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_adr   <= '0;
      req_we    <= 1'b0;
      req_dat   <= '0;
      req_sel   <= '0;
      buf_tag   <= '0;
      buf_valid <= 1'b0;
      cnt       <= 2'd0;
      for (int i = 0; i < 4; i++) buf_mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (req) begin
            req_adr <= wb_adr_i[adr_width-1:2];
            req_we  <= wb_we_i;
            req_dat <= wb_dat_i;
            req_sel <= wb_sel_i;
            if (!wb_we_i && !hit) begin
              buf_valid <= 1'b0;
              buf_tag   <= adr_tag;
            end
          end
        end
        WPUSH: cnt <= cnt + 2'd1;
        WCMD: begin
          if (fml_done && buf_valid && (buf_tag == req_tag)) begin
            for (int b = 0; b < 4; b++)
              if (req_sel[b]) buf_mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
          end
        end
        RCMD: cnt <= 2'd0;
        RFILL: begin
          if (pop) begin
            buf_mem[cnt] <= fml_rdat;
            cnt          <= cnt + 2'd1;
            if (cnt == 2'd3) buf_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state. Data paths are gated to zero outside the
  // states that own them so the bus is quiet when idle or in reset.
  always_comb begin
    wb_ack_o  = 1'b0;
    wb_dat_o  = '0;
    fml_rd    = 1'b0;
    fml_wr    = 1'b0;
    fml_wdat  = '0;
    fml_wbe   = '0;
    fml_wnext = 1'b0;
    fml_rnext = 1'b0;
    fml_adr   = {req_adr[adr_width-1:4], 4'b0000};
    case (state)
      WPUSH: begin
        fml_wnext = 1'b1;
        fml_wdat  = req_dat;
        fml_wbe   = (cnt == req_idx) ? req_sel : 4'b0000;
      end
      WCMD:  fml_wr    = 1'b1;
      RCMD:  fml_rd    = 1'b1;
      RFILL: fml_rnext = !fml_rempty;
      ACK: begin
        wb_ack_o = 1'b1;
        wb_dat_o = req_we ? 32'h0 : buf_mem[req_idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_fml_bridge.sv
// tb_wb_fml_bridge
//   Self-checking bench for wb_fml_bridge. A behavioural FML controller with
//   its own DDR memory answers bursts; a reference model tracks expected
//   memory contents and which line should be buffered.
module tb_wb_fml_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [24:0] fml_adr;
  logic        fml_rd;
  logic        fml_wr;
  logic        fml_done = 1'b0;
  logic [31:0] fml_wdat;
  logic [3:0]  fml_wbe;
  logic        fml_wnext;
  logic        fml_rempty = 1'b1;
  logic        fml_rnext;
  logic [31:0] fml_rdat = '0;

  wb_fml_bridge #(.adr_width(25)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .fml_adr(fml_adr), .fml_rd(fml_rd), .fml_wr(fml_wr), .fml_done(fml_done),
    .fml_wdat(fml_wdat), .fml_wbe(fml_wbe), .fml_wnext(fml_wnext),
    .fml_rempty(fml_rempty), .fml_rnext(fml_rnext), .fml_rdat(fml_rdat)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Controller knobs
  int done_delay = 1;
  int rempty_mode = 0;
  int pop_limit = -1;
  int load_pops = 0;

  // Monitor counters and logs
  int rd_cycles = 0, rd_bursts = 0, wr_bursts = 0, ack_cnt = 0;
  int push_cnt = 0, pop_cnt = 0, empty_pop = 0, overlap_cnt = 0;
  logic [15:0]  wbe_log = '0;
  logic [127:0] wdat_log = '0;
  logic [31:0]  last_cmd_adr = '0;

  logic [31:0] rq [$];
  logic [35:0] wq [$];
  logic [31:0] ctrl_mem [int];
  logic [31:0] ref_mem [int];
  bit ref_valid = 0;
  int ref_line = 0;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
    int          exp_rd;
    int          exp_wr;
    int          exp_lat;
    logic [15:0] exp_wbe;
    logic [31:0] exp_cmd_adr;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] ba;
    ba = w << 2;
    if (ba >= 32'h100 && ba < 32'h110) return 32'hA0 + ((ba - 32'h100) >> 2);
    return 32'hC0DE0000 | {16'h0, ba[15:0]};
  endfunction

  function automatic logic [31:0] ctrl_get(input int w);
    if (ctrl_mem.exists(w)) return ctrl_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] ref_get(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  // Reference: DDR is the truth for every read; the buffer only decides
  // whether a read burst is needed (hit iff the last filled line matches).
  function automatic void model_step(input bit we, input logic [31:0] adr,
                                     input logic [31:0] dat, input logic [3:0] sel,
                                     output logic [31:0] exp_dat, output int exp_rd);
    int w;
    int line;
    logic [31:0] word;
    w = int'(adr[24:2]);
    line = int'(adr[24:4]);
    if (we) begin
      word = ref_get(w);
      for (int b = 0; b < 4; b++) if (sel[b]) word[8*b +: 8] = dat[8*b +: 8];
      ref_mem[w] = word;
      exp_dat = 32'h0;
      exp_rd = 0;
    end else begin
      exp_rd = (ref_valid && ref_line == line) ? 0 : 1;
      ref_valid = 1;
      ref_line = line;
      exp_dat = ref_get(w);
    end
  endfunction

  // Edge monitor: records what the controller accepted on each rising edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (fml_rd && fml_wr) overlap_cnt <= overlap_cnt + 1;
      if (fml_rd) rd_cycles <= rd_cycles + 1;
      if (fml_rd && fml_done) rd_bursts <= rd_bursts + 1;
      if (fml_wr && fml_done) wr_bursts <= wr_bursts + 1;
      if (fml_rd || fml_wr) last_cmd_adr <= {7'h0, fml_adr};
      if (wb_ack_o) ack_cnt <= ack_cnt + 1;
      if (fml_wnext) begin
        push_cnt <= push_cnt + 1;
        wq.push_back({fml_wbe, fml_wdat});
        wbe_log <= {fml_wbe, wbe_log[15:4]};
        wdat_log <= {fml_wdat, wdat_log[127:32]};
      end
      if (fml_rnext) begin
        pop_cnt <= pop_cnt + 1;
        if (fml_rempty) empty_pop <= empty_pop + 1;
        if (rq.size() > 0) void'(rq.pop_front());
      end
    end
  end

  // Behavioural FML controller, driven on the falling edge.
  initial begin
    int cmd_wait;
    int line_w;
    bit toggle_ph;
    bit stall;
    logic [35:0] e;
    logic [31:0] word;
    cmd_wait = 0;
    toggle_ph = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rq.delete();
        wq.delete();
        fml_done = 1'b0;
        fml_rempty = 1'b1;
        fml_rdat = '0;
        cmd_wait = 0;
      end else begin
        if (fml_done) fml_done = 1'b0;
        else if (fml_rd || fml_wr) begin
          cmd_wait++;
          if (cmd_wait >= done_delay) begin
            fml_done = 1'b1;
            cmd_wait = 0;
            line_w = int'(fml_adr) >> 2;
            if (fml_rd) begin
              for (int k = 0; k < 4; k++) rq.push_back(ctrl_get(line_w + k));
              load_pops = pop_cnt;
            end else begin
              for (int k = 0; k < 4; k++) begin
                if (wq.size() > 0) begin
                  e = wq.pop_front();
                  word = ctrl_get(line_w + k);
                  for (int b = 0; b < 4; b++) if (e[32+b]) word[8*b +: 8] = e[8*b +: 8];
                  ctrl_mem[line_w + k] = word;
                end
              end
            end
          end
        end
        toggle_ph = ~toggle_ph;
        stall = 0;
        if (rempty_mode == 1) stall = toggle_ph;
        else if (rempty_mode == 2) stall = ($urandom_range(0, 2) == 0);
        if (pop_limit >= 0 && (pop_cnt - load_pops) >= pop_limit) stall = 1;
        if (rq.size() > 0 && !stall) begin
          fml_rempty = 1'b0;
          fml_rdat = rq[0];
        end else begin
          fml_rempty = 1'b1;
          fml_rdat = 32'hDEAD0000 | $urandom_range(0, 65535);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, {31'h0, wb_ack_o}, 32'h0);
    checkOutput({tag, "_dat_o"}, wb_dat_o, 32'h0);
    checkOutput({tag, "_fml_adr"}, {7'h0, fml_adr}, 32'h0);
    checkOutput({tag, "_rd_wr"}, {30'h0, fml_rd, fml_wr}, 32'h0);
    checkOutput({tag, "_wdat"}, fml_wdat, 32'h0);
    checkOutput({tag, "_wbe_wnext_rnext"}, {26'h0, fml_wbe, fml_wnext, fml_rnext}, 32'h0);
  endtask

  task automatic waitAck(output int lat, output bit got);
    lat = 0;
    got = 0;
    while (!got && lat < 3000) begin
      @(negedge clk);
      lat++;
      got = wb_ack_o;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout: no ack after %0d cycles, expected ack", lat);
    end
  endtask

  // Starts at a falling edge, ends one idle cycle after the ack.
  task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    bit got;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    waitAck(lat, got);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdat, mexp, mexp2;
    int lat, mrd, mrd2, base;
    int s_rd, s_wr, s_ack, s_push, s_pop, s_rdc, s_ep;
    bit got, we;
    logic [31:0] adr, dat;
    logic [3:0] sel;
    vec_t v;

    // adr: we, adr, dat, sel, exp_dat, exp_rd, exp_wr, exp_lat, exp_wbe, exp_cmd_adr
    vecs[0]  = '{1'b0, 32'h104, 32'h0,        4'h0, 32'h000000A1, 1, 0, -1, 16'h0000, 32'h100};
    vecs[1]  = '{1'b0, 32'h108, 32'h0,        4'h0, 32'h000000A2, 0, 0,  1, 16'h0000, 32'h0};
    vecs[2]  = '{1'b1, 32'h10C, 32'h11223344, 4'h3, 32'h00000000, 0, 1, -1, 16'h3000, 32'h100};
    vecs[3]  = '{1'b0, 32'h10C, 32'h0,        4'h0, 32'h00003344, 0, 0,  1, 16'h0000, 32'h0};
    vecs[4]  = '{1'b0, 32'h110, 32'h0,        4'h0, 32'hC0DE0110, 1, 0, -1, 16'h0000, 32'h110};
    vecs[5]  = '{1'b1, 32'h114, 32'hCAFEF00D, 4'hF, 32'h00000000, 0, 1, -1, 16'h00F0, 32'h110};
    vecs[6]  = '{1'b0, 32'h114, 32'h0,        4'h0, 32'hCAFEF00D, 0, 0,  1, 16'h0000, 32'h0};
    vecs[7]  = '{1'b1, 32'h200, 32'hDEADBEEF, 4'h4, 32'h00000000, 0, 1, -1, 16'h0004, 32'h200};
    vecs[8]  = '{1'b0, 32'h200, 32'h0,        4'h0, 32'hC0AD0200, 1, 0, -1, 16'h0000, 32'h200};
    vecs[9]  = '{1'b0, 32'h20C, 32'h0,        4'h0, 32'hC0DE020C, 0, 0,  1, 16'h0000, 32'h0};
    vecs[10] = '{1'b0, 32'h104, 32'h0,        4'h0, 32'h000000A1, 1, 0, -1, 16'h0000, 32'h100};
    vecs[11] = '{1'b0, 32'h10C, 32'h0,        4'h0, 32'h00003344, 0, 0,  1, 16'h0000, 32'h0};

    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      s_rd = rd_bursts; s_wr = wr_bursts; s_ack = ack_cnt; s_push = push_cnt;
      model_step(v.we, v.adr, v.dat, v.sel, mexp, mrd);
      applyStimulus(v.we, v.adr, v.dat, v.sel, rdat, lat);
      checkOutput($sformatf("vec%0d_dat", i), rdat, v.exp_dat);
      checkOutput($sformatf("vec%0d_rd_bursts", i), rd_bursts - s_rd, v.exp_rd);
      checkOutput($sformatf("vec%0d_wr_bursts", i), wr_bursts - s_wr, v.exp_wr);
      checkOutput($sformatf("vec%0d_acks", i), ack_cnt - s_ack, 1);
      if (v.exp_lat >= 0) checkOutput($sformatf("vec%0d_hit_latency", i), lat, v.exp_lat);
      if (v.exp_rd + v.exp_wr > 0) checkOutput($sformatf("vec%0d_fml_adr", i), last_cmd_adr, v.exp_cmd_adr);
      if (v.we) begin
        checkOutput($sformatf("vec%0d_pushes", i), push_cnt - s_push, 4);
        checkOutput($sformatf("vec%0d_wbe_seq", i), {16'h0, wbe_log}, {16'h0, v.exp_wbe});
        for (int k = 0; k < 4; k++)
          checkOutput($sformatf("vec%0d_wdat%0d", i, k), wdat_log[32*k +: 32], v.dat);
      end
    end

    // Slow controller: fml_done after 40 cycles, read FIFO flickering.
    done_delay = 40;
    rempty_mode = 1;
    s_rd = rd_bursts; s_rdc = rd_cycles; s_pop = pop_cnt; s_ep = empty_pop;
    model_step(1'b0, 32'h308, 32'h0, 4'h0, mexp, mrd);
    applyStimulus(1'b0, 32'h308, 32'h0, 4'h0, rdat, lat);
    checkOutput("slow_dat", rdat, mexp);
    checkOutput("slow_rd_cycles", rd_cycles - s_rdc, 40);
    checkOutput("slow_rd_bursts", rd_bursts - s_rd, mrd);
    checkOutput("slow_pops", pop_cnt - s_pop, 4);
    checkOutput("slow_empty_pops", empty_pop - s_ep, 0);
    checkOutput("slow_fml_adr", last_cmd_adr, 32'h300);
    done_delay = 1;
    rempty_mode = 0;

    // Reset in the middle of a fill after two pops.
    pop_limit = 2;
    base = pop_cnt;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h404;
    lat = 0;
    while ((pop_cnt - base) < 2 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("rst_two_pops_seen", pop_cnt - base, 2);
    repeat (2) @(negedge clk);
    checkOutput("rst_no_ack_while_stalled", {31'h0, wb_ack_o}, 32'h0);
    #2 reset = 1'b1;
    #1 checkIdleOutputs("midreset");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ref_valid = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    pop_limit = -1;
    @(negedge clk);
    s_rd = rd_bursts;
    model_step(1'b0, 32'h300, 32'h0, 4'h0, mexp, mrd);
    applyStimulus(1'b0, 32'h300, 32'h0, 4'h0, rdat, lat);
    checkOutput("postrst_300_dat", rdat, mexp);
    checkOutput("postrst_300_refetch", rd_bursts - s_rd, 1);
    s_rd = rd_bursts;
    model_step(1'b0, 32'h404, 32'h0, 4'h0, mexp, mrd);
    applyStimulus(1'b0, 32'h404, 32'h0, 4'h0, rdat, lat);
    checkOutput("postrst_404_dat", rdat, mexp);
    checkOutput("postrst_404_rd_bursts", rd_bursts - s_rd, mrd);

    // Write then read of another line with stb held across the ack.
    s_rd = rd_bursts; s_wr = wr_bursts; s_ack = ack_cnt;
    model_step(1'b1, 32'h500, 32'h5A5A1234, 4'hF, mexp, mrd);
    model_step(1'b0, 32'h604, 32'h0, 4'h0, mexp2, mrd2);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h500; wb_dat_i = 32'h5A5A1234; wb_sel_i = 4'hF;
    waitAck(lat, got);
    checkOutput("b2b_write_dat_o", wb_dat_o, mexp);
    wb_we_i = 1'b0; wb_adr_i = 32'h604;
    waitAck(lat, got);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    checkOutput("b2b_read_dat", rdat, mexp2);
    checkOutput("b2b_acks", ack_cnt - s_ack, 2);
    checkOutput("b2b_wr_bursts", wr_bursts - s_wr, 1);
    checkOutput("b2b_rd_bursts", rd_bursts - s_rd, mrd2);

    // Random traffic against the reference model.
    rempty_mode = 2;
    for (int n = 0; n < 80; n++) begin
      we = ($urandom_range(0, 2) == 0);
      adr = 32'h1000 + 32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 3)) * 4;
      adr[31:25] = 7'($urandom_range(0, 127));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      done_delay = $urandom_range(1, 6);
      s_rd = rd_bursts; s_wr = wr_bursts;
      model_step(we, adr, dat, sel, mexp, mrd);
      applyStimulus(we, adr, dat, sel, rdat, lat);
      checkOutput($sformatf("rnd%0d_dat", n), rdat, mexp);
      checkOutput($sformatf("rnd%0d_rd_bursts", n), rd_bursts - s_rd, mrd);
      checkOutput($sformatf("rnd%0d_wr_bursts", n), wr_bursts - s_wr, {31'h0, we});
    end

    checkOutput("rd_wr_overlap", overlap_cnt, 0);
    checkOutput("pops_while_empty", empty_pop, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
